// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM-stage load/store unit driving a req/ack data-memory port.
// Stalls the pipeline while an access is in flight and sign/zero-extends load data.
module mem_access_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_mem_read,
  input  logic        mem_mem_write,
  input  logic        mem_wb_reg_file,
  input  logic [2:0]  mem_funct3,
  input  logic [31:0] mem_calculated_result,
  input  logic [31:0] mem_store_data,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  output logic        mem_stall,
  output logic        mem_misaligned,
  output logic        mem_bus_err,
  output logic        out_mem_read,
  output logic        out_wb_reg_file,
  output logic [31:0] out_read_data,
  output logic [31:0] out_calculated_result,
  output logic [4:0]  out_rd
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic          ld_r;
  logic [2:0]    f3_r;
  logic [1:0]    off_r;

  logic          access_s;
  logic          is_half_s;
  logic          is_word_s;
  logic          misaligned_s;
  logic          issue_s;
  logic [3:0]    be_s;
  logic [31:0]   wdata_s;

  // Pick the addressed byte/half out of the word and extend it by funct3.
  function automatic logic [31:0] extend_load(input logic [2:0]  f3,
                                              input logic [1:0]  off,
                                              input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = rdata[{off, 3'b000} +: 8];
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      3'd0:    r = {{24{b[7]}}, b};
      3'd1:    r = {{16{h[15]}}, h};
      3'd4:    r = {24'd0, b};
      3'd5:    r = {16'd0, h};
      default: r = rdata;
    endcase
    return r;
  endfunction

  // Decode access size, alignment, lanes, stall and writeback gating.
  always_comb begin
    access_s     = mem_mem_read | mem_mem_write;
    is_half_s    = (mem_funct3[1:0] == 2'b01);
    is_word_s    = mem_funct3[1];
    misaligned_s = access_s & ((is_half_s & mem_calculated_result[0]) |
                               (is_word_s & (mem_calculated_result[1:0] != 2'b00)));
    issue_s      = (state_r == IDLE) & access_s & ~misaligned_s;
    case (mem_funct3[1:0])
      2'b00: begin
        be_s    = 4'b0001 << mem_calculated_result[1:0];
        wdata_s = {4{mem_store_data[7:0]}};
      end
      2'b01: begin
        be_s    = 4'b0011 << mem_calculated_result[1:0];
        wdata_s = {2{mem_store_data[15:0]}};
      end
      default: begin
        be_s    = 4'b1111;
        wdata_s = mem_store_data;
      end
    endcase
    if (mem_mem_read) begin
      be_s = 4'b1111;
    end else begin
      be_s = be_s;
    end
    case (state_r)
      IDLE:    mem_stall = issue_s;
      REQ:     mem_stall = 1'b1;
      default: mem_stall = 1'b0;
    endcase
    mem_misaligned        = misaligned_s;
    out_wb_reg_file       = mem_wb_reg_file & ~misaligned_s &
                            ~((state_r == DONE) & mem_bus_err);
    out_mem_read          = mem_mem_read;
    out_calculated_result = mem_calculated_result;
    out_rd                = mem_rd;
  end

  // Access FSM: issue in IDLE, wait for ack or timeout in REQ, release stall in DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= IDLE;
      cnt_r         <= '0;
      ld_r          <= 1'b0;
      f3_r          <= 3'd0;
      off_r         <= 2'd0;
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= 32'd0;
      dmem_wdata    <= 32'd0;
      dmem_be       <= 4'd0;
      mem_bus_err   <= 1'b0;
      out_read_data <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          mem_bus_err <= 1'b0;
          cnt_r       <= '0;
          if (issue_s) begin
            state_r    <= REQ;
            dmem_req   <= 1'b1;
            dmem_we    <= ~mem_mem_read;
            dmem_addr  <= {mem_calculated_result[31:2], 2'b00};
            dmem_wdata <= wdata_s;
            dmem_be    <= be_s;
            ld_r       <= mem_mem_read;
            f3_r       <= mem_funct3;
            off_r      <= mem_calculated_result[1:0];
          end else begin
            state_r <= IDLE;
          end
        end
        REQ: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            state_r  <= DONE;
            if (ld_r) begin
              out_read_data <= extend_load(f3_r, off_r, dmem_rdata);
            end else begin
              out_read_data <= out_read_data;
            end
          end else if (cnt_r == CW'(TIMEOUT - 1)) begin
            dmem_req    <= 1'b0;
            mem_bus_err <= 1'b1;
            state_r     <= DONE;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        DONE: begin
          mem_bus_err <= 1'b0;
          state_r     <= IDLE;
        end
        default: begin
          dmem_req    <= 1'b0;
          mem_bus_err <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: loads, stores, misalignment, timeout and reset.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_mem_read, mem_mem_write, mem_wb_reg_file;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_calculated_result, mem_store_data, dmem_rdata;
  logic [4:0]  mem_rd;
  logic        dmem_ack;
  logic        dmem_req, dmem_we, mem_stall, mem_misaligned, mem_bus_err;
  logic        out_mem_read, out_wb_reg_file;
  logic [31:0] dmem_addr, dmem_wdata, out_read_data, out_calculated_result;
  logic [3:0]  dmem_be;
  logic [4:0]  out_rd;

  int checks = 0;
  int errors = 0;
  int stall_n, req_n;
  logic [3:0]  snap_be;
  logic        snap_we;
  logic [31:0] snap_addr, snap_wdata;
  logic        snap_stable;

  mem_access_stage #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_wb_reg_file(mem_wb_reg_file), .mem_funct3(mem_funct3),
    .mem_calculated_result(mem_calculated_result), .mem_store_data(mem_store_data),
    .mem_rd(mem_rd), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .mem_stall(mem_stall),
    .mem_misaligned(mem_misaligned), .mem_bus_err(mem_bus_err),
    .out_mem_read(out_mem_read), .out_wb_reg_file(out_wb_reg_file),
    .out_read_data(out_read_data), .out_calculated_result(out_calculated_result),
    .out_rd(out_rd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Present one instruction and run it until the stall drops; ends at the negedge
  // of the first unstalled cycle. waits<0 means the memory never acks.
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] sd,
                        input int waits, input logic [31:0] rdata);
    logic hung;
    @(posedge clk); #1;
    mem_mem_read = rd; mem_mem_write = wr; mem_funct3 = f3;
    mem_calculated_result = addr; mem_store_data = sd; mem_wb_reg_file = 1'b1;
    mem_rd = 5'd3; dmem_ack = 1'b0; dmem_rdata = rdata;
    stall_n = 0; req_n = 0; snap_stable = 1'b1; hung = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!mem_stall) begin
        hung = 1'b0;
        break;
      end
      stall_n++;
      if (dmem_req) begin
        if (req_n == 1) begin
          snap_be = dmem_be; snap_we = dmem_we; snap_addr = dmem_addr; snap_wdata = dmem_wdata;
        end else if ({snap_be, snap_we, snap_addr, snap_wdata} !== {dmem_be, dmem_we, dmem_addr, dmem_wdata}) begin
          snap_stable = 1'b0;
        end
      end
      @(posedge clk); #1;
      if (dmem_req) begin
        req_n++;
        dmem_ack = (waits >= 0) && (req_n == waits + 1);
      end else begin
        dmem_ack = 1'b0;
      end
    end
    dmem_ack = 1'b0;
    check("cycle_budget", {31'd0, hung}, 32'd0);
  endtask

  initial begin
    rst = 1'b0; mem_mem_read = 1'b0; mem_mem_write = 1'b0; mem_wb_reg_file = 1'b0;
    mem_funct3 = 3'd0; mem_calculated_result = 32'h55; mem_store_data = 32'd0;
    mem_rd = 5'd7; dmem_rdata = 32'd0; dmem_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req", {31'd0, dmem_req}, 32'd0);
    check("rst_be", {28'd0, dmem_be}, 32'd0);
    check("rst_addr", dmem_addr, 32'd0);
    check("rst_rdata", out_read_data, 32'd0);
    check("rst_buserr", {31'd0, mem_bus_err}, 32'd0);
    check("pass_result", out_calculated_result, 32'h55);
    check("pass_rd", {27'd0, out_rd}, 32'd7);
    @(posedge clk); #1 rst = 1'b1;

    // LW zero-wait
    access(1'b1, 1'b0, 3'd2, 32'h100, 32'd0, 0, 32'hDEADBEEF);
    check("lw_stall", stall_n, 2);
    check("lw_req_cycles", req_n, 1);
    check("lw_be", {28'd0, snap_be}, 32'hF);
    check("lw_we", {31'd0, snap_we}, 32'd0);
    check("lw_addr", snap_addr, 32'h100);
    check("lw_data", out_read_data, 32'hDEADBEEF);
    check("lw_wb", {31'd0, out_wb_reg_file}, 32'd1);
    check("lw_misal", {31'd0, mem_misaligned}, 32'd0);
    check("lw_req_done", {31'd0, dmem_req}, 32'd0);

    access(1'b1, 1'b0, 3'd0, 32'h103, 32'd0, 0, 32'h80FF1234);
    check("lb_data", out_read_data, 32'hFFFFFF80);
    check("lb_addr", snap_addr, 32'h100);
    access(1'b1, 1'b0, 3'd4, 32'h103, 32'd0, 0, 32'h80FF1234);
    check("lbu_data", out_read_data, 32'h00000080);
    access(1'b1, 1'b0, 3'd0, 32'h100, 32'd0, 0, 32'h80FF1234);
    check("lb0_data", out_read_data, 32'h00000034);
    access(1'b1, 1'b0, 3'd5, 32'h102, 32'd0, 0, 32'h80FF1234);
    check("lhu_data", out_read_data, 32'h000080FF);
    access(1'b1, 1'b0, 3'd1, 32'h102, 32'd0, 0, 32'h80FF1234);
    check("lh_data", out_read_data, 32'hFFFF80FF);

    // Stores
    access(1'b0, 1'b1, 3'd0, 32'h201, 32'h000000AB, 0, 32'h0);
    check("sb_be", {28'd0, snap_be}, 32'b0010);
    check("sb_wdata", snap_wdata, 32'hABABABAB);
    check("sb_we", {31'd0, snap_we}, 32'd1);
    check("sb_addr", snap_addr, 32'h200);
    check("sb_keep_rdata", out_read_data, 32'hFFFF80FF);
    access(1'b0, 1'b1, 3'd1, 32'h202, 32'h1234CDEF, 0, 32'h0);
    check("sh_be", {28'd0, snap_be}, 32'b1100);
    check("sh_wdata", snap_wdata, 32'hCDEFCDEF);
    access(1'b0, 1'b1, 3'd2, 32'h204, 32'h12345678, 1, 32'h0);
    check("sw_be", {28'd0, snap_be}, 32'hF);
    check("sw_wdata", snap_wdata, 32'h12345678);
    check("sw_stall", stall_n, 3);
    check("sw_stable", {31'd0, snap_stable}, 32'd1);

    // Wait states and read+write treated as load
    access(1'b1, 1'b1, 3'd2, 32'h108, 32'hFFFFFFFF, 2, 32'hCAFEF00D);
    check("ws_stall", stall_n, 4);
    check("ws_we", {31'd0, snap_we}, 32'd0);
    check("ws_stable", {31'd0, snap_stable}, 32'd1);
    check("ws_data", out_read_data, 32'hCAFEF00D);

    // Misaligned
    access(1'b1, 1'b0, 3'd2, 32'h102, 32'd0, 0, 32'h0);
    check("mis_lw_flag", {31'd0, mem_misaligned}, 32'd1);
    check("mis_lw_stall", stall_n, 0);
    check("mis_lw_req", {31'd0, dmem_req}, 32'd0);
    check("mis_lw_wb", {31'd0, out_wb_reg_file}, 32'd0);
    access(1'b1, 1'b0, 3'd5, 32'h103, 32'd0, 0, 32'h0);
    check("mis_lhu_flag", {31'd0, mem_misaligned}, 32'd1);
    access(1'b0, 1'b1, 3'd3, 32'h101, 32'd0, 0, 32'h0);
    check("mis_f3_flag", {31'd0, mem_misaligned}, 32'd1);
    check("mis_keep_rdata", out_read_data, 32'hCAFEF00D);

    // Timeout
    access(1'b1, 1'b0, 3'd2, 32'h300, 32'd0, -1, 32'h0);
    check("to_req_cycles", req_n, 16);
    check("to_stall", stall_n, 17);
    check("to_buserr", {31'd0, mem_bus_err}, 32'd1);
    check("to_wb", {31'd0, out_wb_reg_file}, 32'd0);
    check("to_req", {31'd0, dmem_req}, 32'd0);
    check("to_rdata", out_read_data, 32'hCAFEF00D);
    @(posedge clk); #1 mem_mem_read = 1'b0; mem_mem_write = 1'b0;
    @(negedge clk);
    check("to_pulse_end", {31'd0, mem_bus_err}, 32'd0);

    // Async reset during REQ, then spurious ack
    @(posedge clk); #1;
    mem_mem_read = 1'b1; mem_funct3 = 3'd2; mem_calculated_result = 32'h400;
    @(posedge clk); #1;
    check("rr_req_up", {31'd0, dmem_req}, 32'd1);
    #2 rst = 1'b0;
    #1 check("rr_req_drop", {31'd0, dmem_req}, 32'd0);
    mem_mem_read = 1'b0;
    @(posedge clk); #1 rst = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'h11111111;
    @(negedge clk);
    check("rr_ack_req", {31'd0, dmem_req}, 32'd0);
    check("rr_ack_stall", {31'd0, mem_stall}, 32'd0);
    @(posedge clk); #1 dmem_ack = 1'b0;
    @(negedge clk);
    check("rr_ack_rdata", out_read_data, 32'd0);
    access(1'b1, 1'b0, 3'd4, 32'h101, 32'd0, 0, 32'h0000AB00);
    check("rr_after_lbu", out_read_data, 32'h000000AB);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
